// File: rtl/cma_ext_responder.sv
// Host-side responder for the CMA external interface: decodes host accesses to data memory,
// configuration multicast or status registers, and sequences the RUN/DONE core handshake.
module cma_ext_responder #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned GLB_ADR_W  = 18,
    parameter int unsigned ROMULTIC_W = 16,
    parameter int unsigned CFG_IDX_W  = 4,
    parameter int unsigned ERRCNT_W   = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_run,
    input  logic                              i_cbank,
    input  logic                              i_exwe,
    input  logic                              i_exre,
    input  logic [GLB_ADR_W-1:0]              i_exa,
    input  logic [DATA_W-1:0]                 i_exwd,
    input  logic [ROMULTIC_W-1:0]             i_exromul,
    output logic [DATA_W-1:0]                 o_exrd,
    output logic                              o_done,
    output logic                              o_mem_we,
    output logic                              o_mem_re,
    output logic [GLB_ADR_W-3:0]              o_mem_a,
    output logic [DATA_W-1:0]                 o_mem_wd,
    output logic                              o_mem_bank,
    input  logic [DATA_W-1:0]                 i_mem_rd,
    output logic [ROMULTIC_W-1:0]             o_cfg_we,
    output logic [GLB_ADR_W-3-CFG_IDX_W:0]    o_cfg_a,
    output logic [DATA_W-1:0]                 o_cfg_wd,
    output logic                              o_start,
    output logic                              o_abort,
    input  logic                              i_core_done
);

    localparam logic [DATA_W-1:0] ChipId = DATA_W'(32'h434D_4100);

    typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StDone = 2'd2} state_e;

    state_e                  state_q;
    logic                    run_q;
    logic [DATA_W-1:0]       run_cnt;
    logic [ERRCNT_W-1:0]     err_cnt;

    // Stage A: registered host request
    logic                    a_we, a_re;
    logic [GLB_ADR_W-1:0]    a_exa;
    logic [DATA_W-1:0]       a_wd;
    logic [ROMULTIC_W-1:0]   a_romul;

    // Stage B: read result selection
    logic                    b_valid, b_mem;
    logic [DATA_W-1:0]       b_imm;

    logic [1:0]              a_tgt;
    logic                    acc, rd_ok, err_inc, err_clr;
    logic [ROMULTIC_W-1:0]   onehot;
    logic [DATA_W-1:0]       stat;

    always_comb begin
        a_tgt    = a_exa[GLB_ADR_W-1 -: 2];
        acc      = (state_q != StRun);
        rd_ok    = acc && a_re && !a_we;
        onehot   = ROMULTIC_W'(1) << a_exa[GLB_ADR_W-3 -: CFG_IDX_W];
        o_mem_we = acc && a_we && (a_tgt == 2'b00);
        o_mem_re = rd_ok && (a_tgt == 2'b00);
        o_mem_a  = a_exa[GLB_ADR_W-3:0];
        o_mem_wd = a_wd;
        o_cfg_a  = a_exa[GLB_ADR_W-3-CFG_IDX_W:0];
        o_cfg_wd = a_wd;
        o_cfg_we = '0;
        if (acc && a_we && (a_tgt == 2'b01)) begin
            o_cfg_we = (a_romul != '0) ? a_romul : onehot;
        end
        unique case (a_exa[1:0])
            2'd0:    stat = DATA_W'({state_q, o_done, o_mem_bank});
            2'd1:    stat = run_cnt;
            2'd2:    stat = DATA_W'(err_cnt);
            default: stat = ChipId;
        endcase
        // One increment per offending strobe cycle, whatever the cause
        err_inc = (a_we || a_re) &&
                  (!acc || (a_we && a_re) || (a_tgt == 2'b11) ||
                   (a_re && !a_we && (a_tgt == 2'b01)));
        err_clr = acc && a_we && (a_tgt == 2'b10) && (a_exa[1:0] == 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_we    <= 1'b0;
            a_re    <= 1'b0;
            a_exa   <= '0;
            a_wd    <= '0;
            a_romul <= '0;
            b_valid <= 1'b0;
            b_mem   <= 1'b0;
            b_imm   <= '0;
            o_exrd  <= '0;
            err_cnt <= '0;
        end else begin
            a_we    <= i_exwe;
            a_re    <= i_exre;
            a_exa   <= i_exa;
            a_wd    <= i_exwd;
            a_romul <= i_exromul;
            // A read colliding with a write is dropped and leaves o_exrd untouched
            b_valid <= a_re && !a_we;
            b_mem   <= rd_ok && (a_tgt == 2'b00);
            b_imm   <= (rd_ok && (a_tgt == 2'b10)) ? stat : '0;
            if (b_valid) begin
                o_exrd <= b_mem ? i_mem_rd : b_imm;
            end
            if (err_clr) begin
                err_cnt <= '0;
            end else if (err_inc && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERRCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            run_q      <= 1'b0;
            run_cnt    <= '0;
            o_done     <= 1'b0;
            o_start    <= 1'b0;
            o_abort    <= 1'b0;
            o_mem_bank <= 1'b0;
        end else begin
            run_q   <= i_run;
            o_start <= 1'b0;
            o_abort <= 1'b0;
            if (state_q != StRun) begin
                o_mem_bank <= i_cbank;
            end
            case (state_q)
                StIdle: begin
                    if (i_run && !run_q) begin
                        state_q <= StRun;
                        o_start <= 1'b1;
                        run_cnt <= '0;
                    end
                end
                StRun: begin
                    if (run_cnt != '1) begin
                        run_cnt <= run_cnt + DATA_W'(1);
                    end
                    // Core completion takes priority over a simultaneous run drop
                    if (i_core_done) begin
                        state_q <= StDone;
                        o_done  <= 1'b1;
                    end else if (!i_run) begin
                        state_q <= StIdle;
                        o_abort <= 1'b1;
                    end
                end
                StDone: begin
                    if (!i_run) begin
                        state_q <= StIdle;
                        o_done  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cma_ext_responder.sv
// Directed self-checking bench for cma_ext_responder with a small data-memory model.
module tb_cma_ext_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_run, i_cbank, i_exwe, i_exre, i_core_done;
    logic [17:0] i_exa;
    logic [31:0] i_exwd;
    logic [15:0] i_exromul;
    logic [31:0] o_exrd;
    logic        o_done, o_mem_we, o_mem_re, o_mem_bank, o_start, o_abort;
    logic [15:0] o_mem_a;
    logic [31:0] o_mem_wd, o_cfg_wd;
    logic [31:0] i_mem_rd;
    logic [15:0] o_cfg_we;
    logic [11:0] o_cfg_a;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int c0;
    logic [31:0] mem [256];

    cma_ext_responder dut (
        .clk(clk), .rst(rst), .i_run(i_run), .i_cbank(i_cbank), .i_exwe(i_exwe),
        .i_exre(i_exre), .i_exa(i_exa), .i_exwd(i_exwd), .i_exromul(i_exromul),
        .o_exrd(o_exrd), .o_done(o_done), .o_mem_we(o_mem_we), .o_mem_re(o_mem_re),
        .o_mem_a(o_mem_a), .o_mem_wd(o_mem_wd), .o_mem_bank(o_mem_bank), .i_mem_rd(i_mem_rd),
        .o_cfg_we(o_cfg_we), .o_cfg_a(o_cfg_a), .o_cfg_wd(o_cfg_wd), .o_start(o_start),
        .o_abort(o_abort), .i_core_done(i_core_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_mem_we) mem[o_mem_a[7:0]] <= o_mem_wd;
        if (o_mem_re) i_mem_rd <= mem[o_mem_a[7:0]];
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single read: strobe for one cycle, then wait until N+3
    task automatic host_rd(input logic [17:0] a);
        i_exre = 1'b1; i_exa = a;
        step();
        i_exre = 1'b0;
        step();
        step();
    endtask

    task automatic host_wr(input logic [17:0] a, input logic [31:0] d, input logic [15:0] m);
        i_exwe = 1'b1; i_exa = a; i_exwd = d; i_exromul = m;
        step();
        i_exwe = 1'b0; i_exromul = '0;
    endtask

    initial begin
        rst = 1'b1; i_run = 1'b0; i_cbank = 1'b0; i_exwe = 1'b0; i_exre = 1'b0;
        i_core_done = 1'b0; i_exa = '0; i_exwd = '0; i_exromul = '0; i_mem_rd = '0;
        step(); step();
        chk("rst_exrd", o_exrd, 32'h0);
        chk("rst_done", 32'(o_done), 32'h0);
        chk("rst_start", 32'(o_start), 32'h0);
        chk("rst_mem_we", 32'(o_mem_we), 32'h0);
        chk("rst_cfg_we", 32'(o_cfg_we), 32'h0);
        rst = 1'b0;
        step();

        host_rd(18'h20003);
        chk("id_reg", o_exrd, 32'h434D_4100);
        host_rd(18'h20000);
        chk("reg0_idle", o_exrd, 32'h0);

        // Data write then read with exact latency
        i_exwe = 1'b1; i_exa = 18'h00010; i_exwd = 32'hDEADBEEF;
        step();
        i_exwe = 1'b0;
        chk("mem_we", 32'(o_mem_we), 32'h1);
        chk("mem_a", 32'(o_mem_a), 32'h0010);
        chk("mem_wd", o_mem_wd, 32'hDEADBEEF);
        host_wr(18'h00011, 32'hCAFEF00D, 16'h0);
        host_rd(18'h20003);
        i_exre = 1'b1; i_exa = 18'h00010;
        step();
        chk("mem_re", 32'(o_mem_re), 32'h1);
        i_exa = 18'h00011;
        step();
        i_exre = 1'b0;
        chk("rd_lat_hold", o_exrd, 32'h434D_4100);
        step();
        chk("rd_b2b_0", o_exrd, 32'hDEADBEEF);
        step();
        chk("rd_b2b_1", o_exrd, 32'hCAFEF00D);

        // Configuration multicast and single-target writes
        i_exwe = 1'b1; i_exa = 18'h10000; i_exromul = 16'h00F0;
        step();
        chk("cfg_mcast", 32'(o_cfg_we), 32'h00F0);
        chk("cfg_no_mem", 32'(o_mem_we), 32'h0);
        i_exa = 18'h15000; i_exromul = 16'h0;
        step();
        i_exwe = 1'b0;
        chk("cfg_single", 32'(o_cfg_we), 32'h0020);

        // Run handshake with host traffic rejected in RUN
        host_wr(18'h20002, 32'h0, 16'h0);
        i_run = 1'b1;
        step();
        c0 = cyc;
        chk("start_pulse", 32'(o_start), 32'h1);
        host_wr(18'h00010, 32'h1, 16'h0);
        chk("start_once", 32'(o_start), 32'h0);
        chk("run_blk_we0", 32'(o_mem_we), 32'h0);
        host_wr(18'h10000, 32'h2, 16'hFFFF);
        chk("run_blk_cfg", 32'(o_cfg_we), 32'h0);
        host_wr(18'h00011, 32'h3, 16'h0);
        chk("run_blk_we2", 32'(o_mem_we), 32'h0);
        i_exre = 1'b1; i_exa = 18'h00010;
        step();
        chk("run_blk_re", 32'(o_mem_re), 32'h0);
        i_exa = 18'h00011;
        step();
        i_exre = 1'b0;
        step();
        chk("run_rd_zero0", o_exrd, 32'h0);
        while (cyc - c0 < 39) step();
        i_core_done = 1'b1;
        step();
        i_core_done = 1'b0;
        chk("done_set", 32'(o_done), 32'h1);
        host_rd(18'h20002);
        chk("err_run5", o_exrd, 32'h5);
        host_rd(18'h20001);
        chk("runcnt_40", 32'((o_exrd >= 32'd39) && (o_exrd <= 32'd41)), 32'h1);
        host_rd(18'h20000);
        chk("reg0_done", o_exrd, 32'hA);
        host_wr(18'h20002, 32'h0, 16'h0);
        host_rd(18'h20002);
        chk("err_clr", o_exrd, 32'h0);
        i_run = 1'b0;
        step();
        chk("done_clr", 32'(o_done), 32'h0);
        chk("no_abort_done", 32'(o_abort), 32'h0);

        // Abort before core done
        i_run = 1'b1;
        step(); step(); step();
        i_run = 1'b0;
        step();
        chk("abort_pulse", 32'(o_abort), 32'h1);
        chk("abort_nodone", 32'(o_done), 32'h0);
        step();
        chk("abort_once", 32'(o_abort), 32'h0);
        host_rd(18'h20000);
        chk("abort_idle", o_exrd, 32'h0);

        // Done and run fall together: done wins
        i_run = 1'b1;
        step(); step();
        i_run = 1'b0; i_core_done = 1'b1;
        step();
        i_core_done = 1'b0;
        chk("tie_done", 32'(o_done), 32'h1);
        chk("tie_noabort", 32'(o_abort), 32'h0);
        step();
        chk("tie_exit", 32'(o_done), 32'h0);

        // Error cases
        host_wr(18'h20002, 32'h0, 16'h0);
        i_exwe = 1'b1; i_exre = 1'b1; i_exa = 18'h00020; i_exwd = 32'h1234_5678;
        step();
        i_exwe = 1'b0; i_exre = 1'b0;
        chk("wr_rd_we", 32'(o_mem_we), 32'h1);
        chk("wr_rd_nore", 32'(o_mem_re), 32'h0);
        step(); step();
        host_rd(18'h20002);
        chk("wr_rd_err", o_exrd, 32'h1);
        host_rd(18'h30000);
        chk("rsvd_rd", o_exrd, 32'h0);
        host_rd(18'h00020);
        chk("wr_rd_data", o_exrd, 32'h1234_5678);
        i_exwe = 1'b1; i_exa = 18'h30000;
        repeat (70000) @(posedge clk);
        #1;
        i_exwe = 1'b0;
        step();
        host_rd(18'h20002);
        chk("err_sat", o_exrd, 32'hFFFF);

        // Reset discards an in-flight read
        i_exre = 1'b1; i_exa = 18'h20003;
        step();
        i_exre = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("rst_inflight", o_exrd, 32'h0);
        rst = 1'b0;
        i_run = 1'b1;
        step();
        rst = 1'b1; i_run = 1'b0;
        step();
        chk("rst_run_noabort", 32'(o_abort), 32'h0);
        rst = 1'b0;
        step();
        host_rd(18'h20000);
        chk("rst_run_idle", o_exrd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
